instruction_fetch_buffer: RTL

Decoupling queue between `instruction_memory` and `issue_controller`. Each cycle it drives a fetch address and captures `FETCH_WIDTH` instructions one cycle later, tagging each with its PC. It presents up to `FETCH_WIDTH` oldest instructions in program order to the issuer, which consumes any prefix of them. On a PC redirect (JR resolution or rollback) it flushes all buffered and in-flight instructions and refetches from the new PC.

---
 rtl/instruction_fetch_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/instruction_fetch_buffer.sv
// Fetch queue between instruction memory and the issuer: fetches FETCH_WIDTH
// words per cycle, tags each with its PC and presents the oldest in order.
module instruction_fetch_buffer #(
  parameter int unsigned FETCH_WIDTH     = 8,
  parameter int unsigned DEPTH           = 16,
  parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [31:0]                        imem_addr,
  input  logic [FETCH_WIDTH-1:0][31:0]       imem_data,
  input  logic                               redirect_valid,
  input  logic [31:0]                        redirect_pc,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]   out_count,
  output logic [FETCH_WIDTH-1:0][31:0]       out_instr,
  output logic [FETCH_WIDTH-1:0][31:0]       out_pc,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   deq_count,
  output logic                               empty
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned OCW = CW + 1;
  localparam int unsigned OW  = $clog2(FETCH_WIDTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          pending;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic [OCW-1:0] occupied;
  logic           fire;
  logic           enq;

  // Space held by the in-flight fetch is reserved, so a response always fits.
  assign occupied = {1'b0, count} + (pending ? OCW'(FETCH_WIDTH) : '0);
  assign fire     = !redirect_valid && (occupied <= OCW'(DEPTH - FETCH_WIDTH));
  assign enq      = pending && !redirect_valid;

  assign imem_addr = fetch_pc;
  assign empty     = (count == '0);
  assign out_count = (count > CW'(FETCH_WIDTH)) ? OW'(FETCH_WIDTH) : OW'(count);

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      if (k < 32'(out_count)) begin
        out_instr[k] = mem_instr[head + PW'(k)];
        out_pc[k]    = mem_pc[head + PW'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= START_BYTE_ADDR;
      pending_pc <= '0;
      pending    <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      pending  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      pending <= fire;
      if (fire) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'(4 * FETCH_WIDTH);
      end
      if (enq) begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
          mem_instr[tail + PW'(k)] <= imem_data[k];
          mem_pc[tail + PW'(k)]    <= pending_pc + 32'(4 * k);
        end
        tail <= tail + PW'(FETCH_WIDTH);
      end
      head  <= head + PW'(deq_count);
      count <= count + (enq ? CW'(FETCH_WIDTH) : '0) - CW'(deq_count);
    end
  end

endmodule
